// File: rtl/float_to_int_seq.sv
// Sequential IEEE-754 single -> int32 converter, truncating toward zero.
// A 5-stage logarithmic right shifter runs one stage per cycle, giving a fixed 7-cycle latency.
module float_to_int_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        invalid,
  output logic        busy,
  output logic        done_flag
);

  typedef enum logic [1:0] {IDLE, CLASS, SHIFT, SIGN} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] m_q, m_d;
  logic        sticky_q, sticky_d;
  logic        inv_q, inv_d;
  logic [4:0]  sa_q, sa_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] d_q, d_d;
  logic        p_lost_q, p_lost_d;
  logic        invalid_q, invalid_d;
  logic        done_q, done_d;

  logic [7:0]  exp_w;
  logic [22:0] frac_w;
  logic        sign_w;

  // Candidate result of each shifter stage; the active stage is picked by cnt_q.
  logic [31:0] sh_m    [5];
  logic        sh_lost [5];

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int W = 1 << gi;
      assign sh_m[gi]    = m_q >> W;
      assign sh_lost[gi] = |m_q[W-1:0];
    end
  endgenerate

  assign exp_w  = a_q[30:23];
  assign frac_w = a_q[22:0];
  assign sign_w = a_q[31];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    sticky_d  = sticky_q;
    inv_d     = inv_q;
    sa_d      = sa_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    p_lost_d  = p_lost_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          state_d = CLASS;
        end
      end
      CLASS: begin
        // 158 - e truncated to 5 bits equals 30 - e[4:0] modulo 32.
        sa_d  = 5'd30 - exp_w[4:0];
        cnt_d = 3'd4;
        if (exp_w < 8'd127) begin
          m_d      = '0;
          sticky_d = |a_q[30:0];
          inv_d    = 1'b0;
        end else if (exp_w == 8'd255 || exp_w > 8'd158 ||
                     (exp_w == 8'd158 && !(sign_w && frac_w == '0))) begin
          m_d      = '0;
          sticky_d = 1'b0;
          inv_d    = 1'b1;
        end else begin
          m_d      = {1'b1, frac_w, 8'b0};
          sticky_d = 1'b0;
          inv_d    = 1'b0;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sa_q[cnt_q]) begin
          m_d      = sh_m[cnt_q];
          sticky_d = sticky_q | sh_lost[cnt_q];
        end
        if (cnt_q == 3'd0) state_d = SIGN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      SIGN: begin
        d_d       = inv_q ? 32'h8000_0000 : (sign_w ? (~m_q + 32'd1) : m_q);
        p_lost_d  = sticky_q;
        invalid_d = inv_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      sticky_q  <= 1'b0;
      inv_q     <= 1'b0;
      sa_q      <= '0;
      cnt_q     <= '0;
      d_q       <= '0;
      p_lost_q  <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      sticky_q  <= sticky_d;
      inv_q     <= inv_d;
      sa_q      <= sa_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      p_lost_q  <= p_lost_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign d         = d_q;
  assign p_lost    = p_lost_q;
  assign invalid   = invalid_q;
  assign busy      = (state_q != IDLE);
  assign done_flag = done_q;

endmodule

// File: tb/tb_float_to_int_seq.sv
// Directed bench for float_to_int_seq: driver pushes expected results, a monitor pops on done_flag.
module tb_float_to_int_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;
  logic        busy;
  logic        done_flag;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        p;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  float_to_int_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .d         (d),
    .p_lost    (p_lost),
    .invalid   (invalid),
    .busy      (busy),
    .done_flag (done_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done_flag) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done_flag=1 d=%h with no conversion outstanding", d);
        end else begin
          e = sb.pop_front();
          if (d !== e.d || p_lost !== e.p || invalid !== e.inv) begin
            n_fail++;
            $display("FAIL result a=%h: got d=%h p_lost=%b invalid=%b, want d=%h p_lost=%b invalid=%b",
                     e.a, d, p_lost, invalid, e.d, e.p, e.inv);
          end else begin
            $display("[TB] a=%h -> d=%h p_lost=%b invalid=%b ok", e.a, d, p_lost, invalid);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns in the done cycle.
  task automatic issue(input logic [31:0] av, input logic [31:0] ed, input logic ep, input logic ei);
    exp_t e;
    int   win_bad;
    e.a = av; e.d = ed; e.p = ep; e.inv = ei;
    start = 1'b1;
    a     = av;
    sb.push_back(e);
    win_bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        a     = $urandom;
      end
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      if (busy !== 1'b1 || done_flag !== 1'b0) win_bad++;
    end
    check($sformatf("busy_window %h", av), 32'(win_bad), 32'd0);
    @(negedge clk);
    check($sformatf("done_latency %h", av), {30'd0, done_flag, busy}, 32'h2);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("done_pulse_width", {31'd0, done_flag}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    repeat (2) @(negedge clk);
    check("reset_d", d, 32'd0);
    check("reset_flags", {28'd0, p_lost, invalid, busy, done_flag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0); idle_cycle();
    issue(32'hC020_0000, 32'hFFFF_FFFE, 1'b1, 1'b0); idle_cycle();
    issue(32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0); idle_cycle();
    check("hold_between_done", {31'd0, p_lost}, 32'd1);
    issue(32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0); idle_cycle();
    issue(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0); idle_cycle();
    issue(32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b1); idle_cycle();
    issue(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0); idle_cycle();
    issue(32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1); idle_cycle();
    issue(32'h7F80_0000, 32'h8000_0000, 1'b0, 1'b1); idle_cycle();
    issue(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0); idle_cycle();
    issue(32'hBFC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0); idle_cycle();
    // Back-to-back: the second start lands in the first conversion's done cycle.
    issue(32'h4CEB_79A3, 32'h075B_CD18, 1'b0, 1'b0);
    issue(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0); idle_cycle();

    // Abort with reset mid-conversion; nothing is pushed, so any done pulse is flagged.
    issue(32'h4CEB_79A3, 32'h075B_CD18, 1'b0, 1'b0); idle_cycle();
    start = 1'b1;
    a     = 32'h4000_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_d", d, 32'd0);
    check("abort_flags", {28'd0, p_lost, invalid, busy, done_flag}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_flag !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("abort_no_done", 32'(stray), 32'd0);
    issue(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0); idle_cycle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/float_to_int_seq.md
Name: float_to_int_seq

Overview:
- Multi-cycle converter from IEEE-754 single-precision float to 32-bit two's-complement integer, truncating toward zero.
- Sits in the FPU datapath beside the integer-to-float converter and serves as the float-side exit to the integer register file.
- Uses a start/done handshake. A 5-step logarithmic right shifter executes one stage per cycle.
- Reports precision loss and invalid-operation status.

Parameters:
- none (widths fixed at 32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  32  float operand {sign, exp[7:0], frac[22:0]}.
- d  output  32  integer result.
- p_lost  output  1  nonzero bits discarded by truncation.
- invalid  output  1  NaN, Inf or out-of-range operand.
- busy  output  1  conversion in progress (state != IDLE).
- done_flag  output  1  one-cycle pulse when d, p_lost and invalid are updated.

Behaviour:
- Reset (async, rst_n=0) forces state=IDLE, d=0, p_lost=0, invalid=0, done_flag=0 and clears all internal registers. Reset mid-conversion aborts it; no done_flag is produced.
- States: IDLE, CLASS, SHIFT, SIGN.
  - IDLE: on start=1, capture a into a_r, go to CLASS. start=0 stays in IDLE.
  - CLASS (1 cycle):
    - e = a_r[30:23]; m = {1'b1, a_r[22:0], 8'b0}; sa = 158 - e (5 bits, valid for 127 <= e <= 158).
    - e < 127 (includes zero and denormals): m=0; sticky = |a_r[30:0].
    - e == 255, or e > 158, or (e == 158 and not (sign=1 and frac=0)): inv_r=1, m=0, sticky=0.
    - otherwise inv_r=0, sticky=0.
    - Load cnt=4, go to SHIFT.
  - SHIFT (5 cycles, cnt 4..0): if sa[cnt], then sticky |= OR of the low 2^cnt bits of m, and m >>= 2^cnt. Decrement cnt; at cnt==0 go to SIGN.
  - SIGN (1 cycle):
    - d = inv_r ? 32'h8000_0000 : (sign ? -m : m).
    - p_lost = sticky; invalid = inv_r; done_flag=1; go to IDLE.
- Fixed latency:
  - start sampled at edge k gives done_flag high during the cycle after edge k+7, with outputs valid from edge k+7.
  - busy is high from edge k to edge k+7.
  - Special cases take the same 7 cycles.
- Back-to-back: start asserted in the done_flag cycle is accepted, because state is already IDLE.
- start while busy is ignored, not queued. Changes on a after capture are ignored.
- d, p_lost and invalid hold their values between done pulses. done_flag is 0 except for the single pulse.
- Exact -2^31 (0xCF00_0000): sa=0, m=0x8000_0000, negation yields 0x8000_0000, invalid=0.
- -0.0 gives d=0, p_lost=0, invalid=0.
- Negation is 32-bit modular. No other overflow is possible because the range is checked in CLASS.

Test Plan:
- a=0x3F80_0000 (1.0), start pulse -> after 7 cycles done_flag=1, d=1, p_lost=0, invalid=0; busy high for exactly 7 cycles.
- a=0xC020_0000 (-2.5) -> d=0xFFFF_FFFE, p_lost=1, invalid=0.
- a=0x3F00_0000 (0.5) -> d=0, p_lost=1. a=0x0000_0001 (denormal) -> d=0, p_lost=1. a=0x8000_0000 -> d=0, p_lost=0.
- a=0x4F00_0000 (2^31) -> d=0x8000_0000, invalid=1. a=0xCF00_0000 -> d=0x8000_0000, invalid=0, p_lost=0. a=0x7FC0_0000 (NaN) -> invalid=1.
- a=0x4CEB_79A3 (123456792.0) -> d=0x075B_CD18, p_lost=0. Start again in the done cycle with a=0x3F80_0000 -> second done exactly 7 cycles later, d=1.
- Start a conversion, drop rst_n at cycle 3 -> outputs 0 and state IDLE immediately, no done_flag. After release, a new conversion completes normally. start pulses while busy produce no extra done_flag.
